// File: rtl/dmem_responder.sv
// Word-addressed data memory target: accepts one request, waits LATENCY cycles, completes with a one-cycle ready pulse (ready LATENCY+1 cycles after req).
// No backpressure: the initiator holds req/we/addr/wdata until ready; bad addresses complete with err instead of aliasing.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      state, nextState;
    logic [3:0]  cnt, nextCnt;
    logic        capture, doAccess;
    logic        capWe;
    logic [31:0] capAddr, capWdata;
    logic        accWe, addrErr;
    logic [31:0] accAddr, accWdata;
    logic [DEPTH_LOG2-1:0] index;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        capture   = 1'b0;
        doAccess  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (LATENCY == 0) begin
                        doAccess  = 1'b1;
                        nextState = RESP;
                    end else begin
                        nextCnt   = CNT_INIT;
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    doAccess  = 1'b1;
                    nextState = RESP;
                end else begin
                    nextCnt = cnt - 4'd1;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // With zero latency the access happens on the capture edge, so use the live inputs.
    assign accWe    = capture ? we    : capWe;
    assign accAddr  = capture ? addr  : capAddr;
    assign accWdata = capture ? wdata : capWdata;
    assign addrErr  = (|accAddr[1:0]) | (|accAddr[31:DEPTH_LOG2+2]);
    assign index    = accAddr[DEPTH_LOG2+1:2];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            capWe    <= 1'b0;
            capAddr  <= 32'd0;
            capWdata <= 32'd0;
            ready    <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'd0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            ready <= doAccess;
            err   <= doAccess & addrErr;
            if (capture) begin
                capWe    <= we;
                capAddr  <= addr;
                capWdata <= wdata;
            end
            if (doAccess) begin
                if (addrErr)
                    rdata <= 32'd0;
                else if (!accWe)
                    rdata <= mem[index];
            end
        end
    end

    // Array has no reset; a write is suppressed while reset is held so aborted stores never land.
    always_ff @(posedge clk) begin
        if (reset && doAccess && accWe && !addrErr)
            mem[index] <= accWdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances, vector table plus corner sequences.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req2, we2, ready2, err2, busy2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        req0, we0, ready0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) dutL2 (
        .clk(clk), .reset(rstN), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .ready(ready2), .rdata(rdata2), .err(err2), .busy(busy2));

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(0)) dutL0 (
        .clk(clk), .reset(rstN), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0));

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        expErr;
        logic [31:0] expRd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req2 = r; we2 = w; addr2 = a; wdata2 = d;
        end
    endtask

    function automatic logic busyOf(input bit sel);
        return sel ? busy0 : busy2;
    endfunction

    function automatic logic readyOf(input bit sel);
        return sel ? ready0 : ready2;
    endfunction

    // One request; cycle 0 is the cycle req is first high. Returns cycle of ready relative and absolute.
    task automatic doReq(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit dropEarly, output int relCyc, output int absCyc,
                         output logic e, output logic [31:0] rd);
        int  lat;
        bit  seen;
        lat    = sel ? 0 : 2;
        seen   = 0;
        relCyc = -1;
        absCyc = -1;
        e      = 1'bx;
        rd     = 32'hx;
        @(posedge clk); #1;
        check("idle_busy", {31'd0, busyOf(sel)}, 32'd0);
        check("idle_ready", {31'd0, readyOf(sel)}, 32'd0);
        drive(sel, 1'b1, w, a, d);
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (c == 1 && dropEarly) drive(sel, 1'b0, ~w, 32'hFFFF_FFF3, ~d);
            check("busy", {31'd0, busyOf(sel)}, {31'd0, (c <= lat + 1)});
            if (readyOf(sel)) begin
                seen   = 1;
                relCyc = c;
                absCyc = cyc;
                e      = sel ? err0 : err2;
                rd     = sel ? rdata0 : rdata2;
                drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
            end else begin
                check("err_outside_ready", {31'd0, (sel ? err0 : err2)}, 32'd0);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: no ready within 20 cycles, want one at cycle %0d", lat + 1);
            drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        end
    endtask

    vec_t        vecs[10];
    logic        e;
    logic [31:0] rd;
    int          rel, abs, prevAbs;
    logic [31:0] b2bAddr[3];
    logic [31:0] b2bData[3];

    initial begin
        vecs[0] = '{1'b1, 32'h10,        32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h10,        32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 32'h12,        32'h12345678, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h10,        32'h0,        1'b0, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 32'h100,       32'h0,        1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'hFC,        32'hA5A50001, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'hFC,        32'h0,        1'b0, 32'hA5A50001};
        vecs[7] = '{1'b1, 32'h80000010,  32'h55,       1'b1, 32'h0};
        vecs[8] = '{1'b1, 32'h14,        32'h11111111, 1'b0, 32'h0};
        vecs[9] = '{1'b1, 32'h18,        32'h22222222, 1'b0, 32'h0};
        b2bAddr[0] = 32'h10; b2bData[0] = 32'hDEADBEEF;
        b2bAddr[1] = 32'h14; b2bData[1] = 32'h11111111;
        b2bAddr[2] = 32'h18; b2bData[2] = 32'h22222222;

        rstN = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        #3;
        check("rst_busy", {31'd0, busy2}, 32'd0);
        check("rst_ready", {31'd0, ready2}, 32'd0);
        check("rst_err", {31'd0, err2}, 32'd0);
        check("rst_rdata", rdata2, 32'd0);
        check("rst_busy_l0", {31'd0, busy0}, 32'd0);
        check("rst_rdata_l0", rdata0, 32'd0);
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;

        for (int i = 0; i < 10; i++) begin
            doReq(0, vecs[i].w, vecs[i].a, vecs[i].d, 0, rel, abs, e, rd);
            check($sformatf("vec%0d_latency", i), rel, 32'd3);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].expErr});
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
        end

        prevAbs = -1;
        for (int i = 0; i < 3; i++) begin
            doReq(0, 1'b0, b2bAddr[i], 32'd0, 0, rel, abs, e, rd);
            check($sformatf("b2b%0d_rdata", i), rd, b2bData[i]);
            check($sformatf("b2b%0d_err", i), {31'd0, e}, 32'd0);
            if (i > 0) check($sformatf("b2b%0d_period", i), abs - prevAbs, 32'd4);
            prevAbs = abs;
        end
        repeat (3) @(posedge clk);
        #1 check("rdata_hold", rdata2, 32'h22222222);

        doReq(0, 1'b1, 32'h20, 32'h33, 1, rel, abs, e, rd);
        check("drop_latency", rel, 32'd3);
        check("drop_err", {31'd0, e}, 32'd0);
        doReq(0, 1'b0, 32'h20, 32'd0, 0, rel, abs, e, rd);
        check("drop_readback", rd, 32'h33);

        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("midop_busy_before", {31'd0, busy2}, 32'd1);
        rstN = 1'b0;
        #1;
        check("midop_busy", {31'd0, busy2}, 32'd0);
        check("midop_ready", {31'd0, ready2}, 32'd0);
        check("midop_err", {31'd0, err2}, 32'd0);
        check("midop_rdata", rdata2, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;
        doReq(0, 1'b0, 32'h10, 32'd0, 0, rel, abs, e, rd);
        check("midop_readback", rd, 32'hDEADBEEF);

        doReq(1, 1'b1, 32'h20, 32'h0BADF00D, 0, rel, abs, e, rd);
        check("l0_store_latency", rel, 32'd1);
        check("l0_store_err", {31'd0, e}, 32'd0);
        doReq(1, 1'b0, 32'h20, 32'd0, 0, rel, abs, e, rd);
        check("l0_load_latency", rel, 32'd1);
        check("l0_load_rdata", rd, 32'h0BADF00D);
        doReq(1, 1'b0, 32'h3, 32'd0, 0, rel, abs, e, rd);
        check("l0_misaligned_err", {31'd0, e}, 32'd1);
        check("l0_misaligned_rdata", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
